// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Stimulus/response checker for the seven-gate cluster
//               (AND, OR, NAND, NOR, XOR, XNOR, NOT). On start it walks the
//               gate inputs a,b through all four combinations PASSES times,
//               waits SETTLE_CYCLES after each new vector, compares the
//               captured outputs against the golden truth table and reports
//               pass/fail, a saturating mismatch count and a per-gate mask.
// Ports       : clk          - clock, rising edge
//               rst_n        - synchronous active-low reset
//               i_start      - begin a sweep (sampled only when idle)
//               o_a, o_b     - registered gate inputs
//               i_y[6:0]     - gate outputs {NOT,XNOR,XOR,NOR,NAND,OR,AND}
//               o_busy       - sweep in progress (DRIVE through DONE)
//               o_done       - one-cycle pulse at end of sweep
//               o_pass       - held result, 1 = no mismatching vector
//               o_err_cnt    - mismatching vectors, saturates at 255
//               o_fail_mask  - OR of per-gate mismatches, same order as i_y
//               Optional (GATE_SWEEP_ERRLOG_EN defined):
//               o_first_err_vld, o_first_err_vec[1:0] ({a,b}),
//               o_first_err_mask[6:0] - record of the first bad vector
// Build macro : GATE_SWEEP_ERRLOG_EN enables the first-error log.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_a,
    output logic       o_b,
    input  logic [6:0] i_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_cnt,
    output logic [6:0] o_fail_mask
`ifdef GATE_SWEEP_ERRLOG_EN
    ,
    output logic       o_first_err_vld,
    output logic [1:0] o_first_err_vec,
    output logic [6:0] o_first_err_mask
`endif
);

    // Settle counter runs 0..SETTLE_CYCLES-1; pass index runs 0..PASSES-1.
    localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_LAST =
        c_SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [c_PW-1:0] c_PASS_LAST = c_PW'(PASSES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_a;
    logic            r_b;
    logic [1:0]      r_vec;
    logic [c_PW-1:0] r_pidx;
    logic [c_SW-1:0] r_scnt;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [7:0]      r_err_cnt;
    logic [6:0]      r_fail_mask;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic            r_fe_vld;
    logic [1:0]      r_fe_vec;
    logic [6:0]      r_fe_mask;
`endif

    logic [6:0] w_exp;
    logic [6:0] w_mis;
    logic [7:0] w_err_next;

    // Golden outputs are derived from the registered a,b actually presented
    // to the gates, not from the vector counter.
    assign w_exp = {~r_a, ~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b),
                    ~(r_a & r_b), r_a | r_b, r_a & r_b};
    assign w_mis = i_y ^ w_exp;

    // Count value after this CHECK; also used for the pass verdict so the
    // final vector's mismatch is included.
    assign w_err_next = ((w_mis != 7'd0) && (r_err_cnt != 8'hFF))
                        ? r_err_cnt + 8'd1 : r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_vec       <= 2'd0;
            r_pidx      <= '0;
            r_scnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_fail_mask <= 7'd0;
`ifdef GATE_SWEEP_ERRLOG_EN
            r_fe_vld    <= 1'b0;
            r_fe_vec    <= 2'd0;
            r_fe_mask   <= 7'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_DRIVE;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= 8'd0;
                        r_fail_mask <= 7'd0;
                        r_vec       <= 2'd0;
                        r_pidx      <= '0;
`ifdef GATE_SWEEP_ERRLOG_EN
                        r_fe_vld    <= 1'b0;
                        r_fe_vec    <= 2'd0;
                        r_fe_mask   <= 7'd0;
`endif
                    end
                end

                ST_DRIVE: begin
                    r_a    <= r_vec[1];
                    r_b    <= r_vec[0];
                    r_scnt <= '0;
                    r_state <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (r_scnt == c_SETTLE_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    r_fail_mask <= r_fail_mask | w_mis;
                    r_err_cnt   <= w_err_next;
`ifdef GATE_SWEEP_ERRLOG_EN
                    // Only the first bad vector of the sweep is recorded.
                    if ((w_mis != 7'd0) && !r_fe_vld) begin
                        r_fe_vld  <= 1'b1;
                        r_fe_vec  <= {r_a, r_b};
                        r_fe_mask <= w_mis;
                    end
`endif
                    if (r_vec == 2'd3) begin
                        if (r_pidx == c_PASS_LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 8'd0);
                        end else begin
                            r_pidx  <= r_pidx + 1'b1;
                            r_vec   <= 2'd0;
                            r_state <= ST_DRIVE;
                        end
                    end else begin
                        r_vec   <= r_vec + 2'd1;
                        r_state <= ST_DRIVE;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_cnt   = r_err_cnt;
    assign o_fail_mask = r_fail_mask;
`ifdef GATE_SWEEP_ERRLOG_EN
    assign o_first_err_vld  = r_fe_vld;
    assign o_first_err_vec  = r_fe_vec;
    assign o_first_err_mask = r_fe_mask;
`endif

endmodule
`default_nettype wire
